mem_bus_arbiter: RTL and testbench

Shares the single-ported `Memory` bus between two requesters: master 0 (CPU6 core side) and master 1 (DMA/console engine). Each master issues one byte access at a time over a req/ack handshake. The arbiter sequences each access through a fixed four-state cycle and returns read data with the acknowledge. It sits between the requesters and `Memory`, replacing the direct CPU6-to-`Memory` connection in the top-level and bench.

---
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single-ported Memory bus between master 0 (CPU6)
// and master 1 (DMA/console). Each access runs IDLE/ACK -> ACCESS -> CAPTURE -> ACK.
// Build option: define ARB_ROUND_ROBIN_EN for a round-robin tie-break; otherwise
// master 0 has fixed priority and the round-robin pointer is not built.
module mem_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              winner;
    logic              acc_we;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_next;
`endif

    // Next-state logic and arbitration (IDLE and ACK are the only grant points)
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        winner     = owner;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    winner     = (m0_req && m1_req) ? rr_next : !m0_req;
`else
                    winner     = !m0_req;
`endif
                end
            end
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK: begin
                // The owner is still dropping its req here, so only the other master counts
`ifdef ARB_ROUND_ROBIN_EN
                if (owner ? m0_req : m1_req) begin
`else
                if (owner ? m0_req : (m1_req && !m0_req)) begin
`endif
                    grant      = 1'b1;
                    winner     = !owner;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the winning master's access qualifiers
    always_comb begin
        win_we    = winner ? m1_we    : m0_we;
        win_addr  = winner ? m1_addr  : m0_addr;
        win_wdata = winner ? m1_wdata : m0_wdata;
    end

    // State, ownership, bus drive and read-data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            acc_we    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_next   <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            mem_we <= grant && win_we;
            if (grant) begin
                owner     <= winner;
                acc_we    <= win_we;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                rr_next   <= !winner;
`endif
            end
            if (state == CAPTURE && !acc_we) begin
                if (owner) begin
                    m1_rdata <= mem_rdata;
                end else begin
                    m0_rdata <= mem_rdata;
                end
            end
        end
    end

    assign m0_ack = (state == ACK) && !owner;
    assign m1_ack = (state == ACK) && owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed plus randomized bench for mem_bus_arbiter with a
// timeline-based reference model (grant edge g: bus op in cycle g, ack in g+2,
// next arbitration at edge g+3) and a behavioural synchronous memory.
module tb_mem_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          rq [2];
    logic          wq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    logic          m0_ack, m1_ack, mem_we, owner;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .m0_req(rq[0]), .m0_we(wq[0]), .m0_addr(aq[0]), .m0_wdata(dq[0]),
        .m1_req(rq[1]), .m1_we(wq[1]), .m1_addr(aq[1]), .m1_wdata(dq[1]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    function automatic logic [7:0] fill(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Behavioural memory: unwritten locations read as fill(addr)
    logic [7:0]  env_mem   [0:65535];
    bit          env_valid [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;
    always @(posedge clock) begin
        if (pl_en) begin
            env_mem[pl_addr]   <= pl_data;
            env_valid[pl_addr] <= 1'b1;
        end else if (mem_we) begin
            env_mem[mem_addr]   <= mem_wdata;
            env_valid[mem_addr] <= 1'b1;
        end
        mem_rdata <= env_valid[mem_addr] ? env_mem[mem_addr] : fill(mem_addr);
    end

    // Reference model state
    logic [7:0]  ref_mem [0:65535];
    int          e, g_edge, g_who, favored, exp_owner;
    bit          have_g, g_we;
    logic [15:0] g_addr, exp_addr;
    logic [7:0]  g_wdata, rd_val, exp_wdata;
    logic [7:0]  exp_rd [2];
    bit          exp_ack [2];
    int          gap [2];
    bit          auto_raise;
    int          raise_pct, gap_max;
    int          n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic raise(input int w, input bit we, input logic [15:0] a, input logic [7:0] dat);
        rq[w] = 1'b1;
        wq[w] = we;
        aq[w] = a;
        dq[w] = dat;
    endtask

    task automatic tick();
        bit          r  [2];
        bit          wv [2];
        logic [15:0] av [2];
        logic [7:0]  dv [2];
        bit          rst, gr;
        int          d, w;
        for (int i = 0; i < 2; i++) begin
            r[i] = rq[i]; wv[i] = wq[i]; av[i] = aq[i]; dv[i] = dq[i];
        end
        rst = reset;
        @(posedge clock);
        e++;
        d = have_g ? e - g_edge : 1000;
        if (d == 1) begin
            if (g_we) ref_mem[g_addr] = g_wdata;
            else      rd_val = ref_mem[g_addr];
        end
        if (rst) begin
            have_g = 0; exp_owner = 0; exp_addr = '0; exp_wdata = '0;
            exp_rd[0] = '0; exp_rd[1] = '0; favored = 0;
        end else begin
            if (d == 2 && !g_we) exp_rd[g_who] = rd_val;
            gr = 0;
            w  = 0;
            if (d == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (r[1-g_who]) begin gr = 1; w = 1 - g_who; end
`else
                if (g_who == 1 && r[0]) begin gr = 1; w = 0; end
                else if (g_who == 0 && r[1] && !r[0]) begin gr = 1; w = 1; end
`endif
            end else if (d > 3) begin
                if (r[0] && r[1]) begin
                    gr = 1;
`ifdef ARB_ROUND_ROBIN_EN
                    w = favored;
`else
                    w = 0;
`endif
                end else if (r[0]) begin gr = 1; w = 0; end
                else if (r[1]) begin gr = 1; w = 1; end
            end
            if (gr) begin
                have_g = 1; g_edge = e; g_who = w;
                g_we = wv[w]; g_addr = av[w]; g_wdata = dv[w];
                favored = 1 - w; exp_owner = w; exp_addr = av[w]; exp_wdata = dv[w];
            end
        end
        #1;
        d = have_g ? e - g_edge : 1000;
        exp_ack[0] = (d == 2) && (g_who == 0);
        exp_ack[1] = (d == 2) && (g_who == 1);
        check("m0_ack", m0_ack, exp_ack[0]);
        check("m1_ack", m1_ack, exp_ack[1]);
        check("mem_we", mem_we, (d == 0) && g_we);
        check("owner", owner, exp_owner);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_wdata);
        check("m0_rdata", m0_rdata, exp_rd[0]);
        check("m1_rdata", m1_rdata, exp_rd[1]);
        for (int i = 0; i < 2; i++) begin
            if (rq[i]) begin
                if (exp_ack[i]) begin
                    rq[i]  = 1'b0;
                    gap[i] = $urandom_range(0, gap_max);
                end
            end else if (auto_raise) begin
                if (gap[i] > 0) gap[i]--;
                else if ($urandom_range(0, 99) < raise_pct)
                    raise(i, 1'($urandom_range(0, 1)), 16'h4000 + 16'($urandom_range(0, 7)), 8'($urandom));
            end
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] dat);
        pl_en = 1'b1; pl_addr = a; pl_data = dat;
        ref_mem[a] = dat;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((rq[0] || rq[1] || (have_g && e - g_edge < 3)) && n < limit) begin
            tick();
            n++;
        end
        check("drain_bound", n < limit, 1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; e = 0; g_edge = 0; g_who = 0; have_g = 0; g_we = 0;
        favored = 0; exp_owner = 0; exp_addr = '0; exp_wdata = '0; rd_val = '0;
        g_addr = '0; g_wdata = '0; auto_raise = 0; raise_pct = 0; gap_max = 0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0; wq[i] = 0; aq[i] = '0; dq[i] = '0; exp_rd[i] = '0; exp_ack[i] = 0; gap[i] = 0;
        end
        for (int i = 0; i < 65536; i++) ref_mem[i] = fill(16'(i));
        pl_en = 0; pl_addr = '0; pl_data = '0;
        reset = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_owner", owner, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_acks", {m0_ack, m1_ack}, 0);
        preload(16'h1234, 8'hA5);
        preload(16'h2000, 8'h11);
        reset = 1'b0;
        tick();

        // Single read by master 0
        raise(0, 0, 16'h1234, 8'h00);
        tick(); tick(); tick();
        check("rd_ack", m0_ack, 1);
        check("rd_data", m0_rdata, 8'hA5);
        drain(20);

        // Single write by master 1, then read back by master 0
        raise(1, 1, 16'h5A00, 8'h3C);
        tick();
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 16'h5A00);
        check("wr_data", mem_wdata, 8'h3C);
        tick();
        check("wr_we_drop", mem_we, 0);
        tick();
        check("wr_ack", m1_ack, 1);
        drain(20);
        raise(0, 0, 16'h5A00, 8'h00);
        tick(); tick(); tick();
        check("rdback", m0_rdata, 8'h3C);
        drain(20);

        // Read data held through a later write
        raise(0, 0, 16'h2000, 8'h00);
        tick(); tick(); tick();
        check("hold_rd", m0_rdata, 8'h11);
        drain(20);
        raise(0, 1, 16'h2000, 8'h77);
        tick(); tick(); tick();
        check("hold_wack", m0_ack, 1);
        check("hold_rdata", m0_rdata, 8'h11);
        drain(20);

        // Back-to-back: both pending together
        raise(0, 0, 16'h1234, 8'h00);
        raise(1, 0, 16'h5A00, 8'h00);
        tick(); tick(); tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("b2b_first_ack", {m1_ack, m0_ack}, 2'b10);
        tick();
        check("b2b_switch", owner, 0);
`else
        check("b2b_first_ack", {m1_ack, m0_ack}, 2'b01);
        tick();
        check("b2b_switch", owner, 1);
        check("b2b_ack_width", m0_ack, 0);
`endif
        drain(20);

        // Reset during CAPTURE of a master 0 write
        raise(0, 1, 16'h3000, 8'hC3);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("mrst_ack", m0_ack, 0);
        check("mrst_we", mem_we, 0);
        check("mrst_owner", owner, 0);
        rq[0] = 1'b0;
        reset = 1'b0;
        tick(); tick();
        check("mrst_noack", m0_ack, 0);
        raise(0, 0, 16'h3000, 8'h00);
        tick(); tick(); tick();
        check("mrst_commit", m0_rdata, 8'hC3);
        drain(20);

        // Contention: both held from reset, one-cycle drop after each ack
        reset = 1'b1;
        raise(0, 0, 16'h1234, 8'h00);
        raise(1, 1, 16'h4001, 8'h5E);
        tick();
        reset = 1'b0;
        auto_raise = 1; raise_pct = 100; gap_max = 0;
        for (int i = 0; i < 40; i++) tick();
        auto_raise = 0;
        drain(20);

        // Randomized traffic with occasional resets
        auto_raise = 1; raise_pct = 30; gap_max = 3;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        auto_raise = 0;
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
